// File: rtl/reset_sequencer.sv
// reset_sequencer
//   Reset generator for the FPGA top level. Holds every reset domain asserted
//   for HOLD_CYCLES after a reset event, then releases the domains in index
//   order with STAGGER_CYCLES between each release. Reset events are: the
//   global synchronous reset, a debounced press of the board button, and a
//   CPU soft-reset request (honoured only once the sequence has finished).
//
// Ports
//   clk           system clock, posedge
//   reset         synchronous active-high global reset
//   ext_rst_n     asynchronous active-low board button
//   soft_rst_req  single-cycle CPU soft-reset request
//   rst_out       per-domain active-high reset, registered
//   seq_done      high once every domain is released, registered
//   rst_cause     last reset cause: 0 POR/global, 1 button, 2 soft request
module reset_sequencer #(
    parameter int NUM_DOMAINS     = 3,
    parameter int HOLD_CYCLES     = 16,
    parameter int STAGGER_CYCLES  = 4,
    parameter int DEBOUNCE_CYCLES = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   ext_rst_n,
    input  logic                   soft_rst_req,
    output logic [NUM_DOMAINS-1:0] rst_out,
    output logic                   seq_done,
    output logic [1:0]             rst_cause
);

    localparam int MAX_HS  = (HOLD_CYCLES > STAGGER_CYCLES) ? HOLD_CYCLES : STAGGER_CYCLES;
    localparam int MAX_ALL = (MAX_HS > DEBOUNCE_CYCLES) ? MAX_HS : DEBOUNCE_CYCLES;
    localparam int CW      = $clog2(MAX_ALL + 1);

    localparam logic [NUM_DOMAINS-1:0] ALL_ONES = '1;

    localparam logic [1:0] CAUSE_POR  = 2'd0;
    localparam logic [1:0] CAUSE_BTN  = 2'd1;
    localparam logic [1:0] CAUSE_SOFT = 2'd2;

    typedef enum logic [1:0] {
        S_HOLD    = 2'd0,
        S_RELEASE = 2'd1,
        S_RUN     = 2'd2
    } state_t;

    // Power-up values match reset values so the block sequences even when
    // reset is never asserted.
    logic          sync1     = 1'b1;
    logic          sync2     = 1'b1;
    logic          deb_level = 1'b1;
    logic [CW-1:0] deb_cnt   = '0;
    logic          ext_evt   = 1'b0;

    state_t        state     = S_HOLD;
    logic [CW-1:0] cnt       = '0;

    initial_values_unused_guard : assert property (@(posedge clk) 1'b1);

    state_t                 state_d;
    logic [CW-1:0]          cnt_d;
    logic [NUM_DOMAINS-1:0] rst_d;
    logic                   done_d;
    logic [1:0]             cause_d;
    logic [NUM_DOMAINS-1:0] rel_next;

    // ---------------- button synchroniser + debouncer ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
        end else begin
            sync1 <= ext_rst_n;
            sync2 <= sync1;
        end
    end

    // Counts consecutive samples that disagree with the accepted level; any
    // agreeing sample restarts the count. ext_evt is registered together with
    // the level so it pulses in the first cycle the level reads low.
    always_ff @(posedge clk) begin
        if (reset) begin
            deb_level <= 1'b1;
            deb_cnt   <= '0;
            ext_evt   <= 1'b0;
        end else begin
            ext_evt <= 1'b0;
            if (sync2 != deb_level) begin
                if (deb_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                    deb_level <= sync2;
                    deb_cnt   <= '0;
                    ext_evt   <= ~sync2;
                end else begin
                    deb_cnt <= deb_cnt + CW'(1);
                end
            end else begin
                deb_cnt <= '0;
            end
        end
    end

    // ---------------- sequencing FSM ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_HOLD;
            cnt       <= '0;
            rst_out   <= ALL_ONES;
            seq_done  <= 1'b0;
            rst_cause <= CAUSE_POR;
        end else begin
            state     <= state_d;
            cnt       <= cnt_d;
            rst_out   <= rst_d;
            seq_done  <= done_d;
            rst_cause <= cause_d;
        end
    end

    always_comb begin
        state_d  = state;
        cnt_d    = cnt;
        rst_d    = rst_out;
        done_d   = seq_done;
        cause_d  = rst_cause;
        // Releasing a domain shifts a zero in from the bottom, so domain 0
        // drops first and the vector is empty once the last one drops.
        rel_next = (state == S_HOLD) ? (ALL_ONES << 1) : (rst_out << 1);

        case (state)
            S_HOLD: begin
                rst_d  = ALL_ONES;
                done_d = 1'b0;
                if (!deb_level) begin
                    cnt_d = '0;          // button still held: hold time not started
                end else if (cnt == CW'(HOLD_CYCLES - 1)) begin
                    cnt_d = '0;
                    rst_d = rel_next;
                    if (rel_next == '0) begin
                        state_d = S_RUN;  // single-domain build
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_RELEASE;
                    end
                end else begin
                    cnt_d = cnt + CW'(1);
                end
            end
            S_RELEASE: begin
                if (cnt == CW'(STAGGER_CYCLES - 1)) begin
                    cnt_d = '0;
                    rst_d = rel_next;
                    if (rel_next == '0) begin
                        state_d = S_RUN;
                        done_d  = 1'b1;
                    end
                end else begin
                    cnt_d = cnt + CW'(1);
                end
            end
            S_RUN: begin
                cnt_d  = '0;
                rst_d  = '0;
                done_d = 1'b1;
            end
            default: begin
                state_d = S_HOLD;
                cnt_d   = '0;
                rst_d   = ALL_ONES;
                done_d  = 1'b0;
            end
        endcase

        // Button beats soft request; soft request only counts once running.
        if (ext_evt) begin
            state_d = S_HOLD;
            cnt_d   = '0;
            rst_d   = ALL_ONES;
            done_d  = 1'b0;
            cause_d = CAUSE_BTN;
        end else if (soft_rst_req && state == S_RUN) begin
            state_d = S_HOLD;
            cnt_d   = '0;
            rst_d   = ALL_ONES;
            done_d  = 1'b0;
            cause_d = CAUSE_SOFT;
        end
    end

endmodule

// File: tb/tb_reset_sequencer.sv
module tb_reset_sequencer;

    localparam int N    = 3;
    localparam int HOLD = 16;
    localparam int STAG = 4;
    localparam int DEB  = 8;
    localparam int HMAX = 8192;

    logic         clk;
    logic         reset;
    logic         ext_rst_n;
    logic         soft_rst_req;
    logic [N-1:0] rst_out;
    logic         seq_done;
    logic [1:0]   rst_cause;

    reset_sequencer #(
        .NUM_DOMAINS(N), .HOLD_CYCLES(HOLD),
        .STAGGER_CYCLES(STAG), .DEBOUNCE_CYCLES(DEB)
    ) dut (
        .clk(clk), .reset(reset), .ext_rst_n(ext_rst_n),
        .soft_rst_req(soft_rst_req), .rst_out(rst_out),
        .seq_done(seq_done), .rst_cause(rst_cause)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model, expressed in event times rather than FSM state:
    //   m_R    cycle of the last global reset (debounce history restarts there)
    //   m_A    first cycle after the last restart with the button level high;
    //          domain i is released at m_A + HOLD + i*STAG (-1: not yet)
    //   hist   button value driven in each cycle; the synchronised sample in
    //          cycle s is hist[s-2]
    int           mc;
    int           m_R;
    int           m_A;
    bit           m_lvl;
    bit           m_evt;
    bit           hist [HMAX];
    logic [N-1:0] m_rst;
    logic         m_done;
    logic [1:0]   m_cause;

    function automatic bit sync_at(int s);
        if (s < m_R + 2) return 1'b1;
        return hist[s-2];
    endfunction

    // Drive one cycle of inputs, advance the model to the next cycle and
    // land 1 time unit after the next rising edge.
    task automatic tick(input bit e, input bit s, input bit r);
        int c;
        bit nl;
        bit all_diff;
        bit run_now;
        ext_rst_n    = e;
        soft_rst_req = s;
        reset        = r;
        if (mc < HMAX) hist[mc] = e;
        c = mc + 1;
        if (r) begin
            m_R = c; m_lvl = 1'b1; m_evt = 1'b0; m_cause = 2'd0; m_A = c;
        end else begin
            run_now = (m_A >= 0) && (mc >= m_A + HOLD + (N-1)*STAG);
            nl = m_lvl;
            if (c - DEB >= m_R) begin
                all_diff = 1'b1;
                for (int q = c - DEB; q < c; q++)
                    if (sync_at(q) == m_lvl) all_diff = 1'b0;
                if (all_diff) nl = !m_lvl;
            end
            if (m_evt) begin
                m_cause = 2'd1; m_A = -1;
            end else if (s && run_now) begin
                m_cause = 2'd2; m_A = -1;
            end
            m_evt = m_lvl && !nl;
            m_lvl = nl;
            if (m_A < 0 && m_lvl) m_A = c;
        end
        for (int i = 0; i < N; i++)
            m_rst[i] = !((m_A >= 0) && (c >= m_A + HOLD + i*STAG));
        m_done = (m_A >= 0) && (c >= m_A + HOLD + (N-1)*STAG);
        mc = c;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [N-1:0] exp_r;
        tick(1, 0, 1);
        tick(1, 0, 1);
        for (int j = 0; j < 30; j++) begin
            exp_r = (j < 16) ? 3'b111 : (j < 20) ? 3'b110 : (j < 24) ? 3'b100 : 3'b000;
            n_cmp++;
            if ({rst_out, seq_done, rst_cause} !== {exp_r, 1'(j >= 24), 2'd0}) begin
                n_err++;
                $display("FAIL por_timing cyc=%0d got=%b/%b/%0d exp=%b/%b/0", j, rst_out, seq_done, rst_cause, exp_r, j >= 24);
            end
            n_cmp++;
            if ({rst_out, seq_done, rst_cause} !== {m_rst, m_done, m_cause}) begin
                n_err++;
                $display("FAIL por_model cyc=%0d got=%b/%b/%0d exp=%b/%b/%0d", j, rst_out, seq_done, rst_cause, m_rst, m_done, m_cause);
            end
            tick(1, 0, 0);
        end
    endtask

    task automatic test_short_press();
        for (int j = 0; j < 25; j++) begin
            n_cmp++;
            if ({rst_out, seq_done, rst_cause} !== {3'b000, 1'b1, 2'd0}) begin
                n_err++;
                $display("FAIL short_press cyc=%0d got=%b/%b/%0d exp=000/1/0", j, rst_out, seq_done, rst_cause);
            end
            tick(j >= 5, 0, 0);
        end
    endtask

    task automatic test_long_press();
        logic [N-1:0] exp_r;
        for (int j = 0; j < 30; j++) begin
            exp_r = (j < 11) ? 3'b000 : 3'b111;
            n_cmp++;
            if ({rst_out, rst_cause} !== {exp_r, 2'(j < 11 ? 0 : 1)}) begin
                n_err++;
                $display("FAIL long_press cyc=%0d got=%b/%0d exp=%b/%0d", j, rst_out, rst_cause, exp_r, j < 11 ? 0 : 1);
            end
            tick(0, 0, 0);
        end
        for (int u = 0; u < 40; u++) begin
            exp_r = (u < 26) ? 3'b111 : (u < 30) ? 3'b110 : (u < 34) ? 3'b100 : 3'b000;
            n_cmp++;
            if ({rst_out, seq_done, rst_cause} !== {exp_r, 1'(u >= 34), 2'd1}) begin
                n_err++;
                $display("FAIL btn_release cyc=%0d got=%b/%b/%0d exp=%b/%b/1", u, rst_out, seq_done, rst_cause, exp_r, u >= 34);
            end
            n_cmp++;
            if ({rst_out, seq_done, rst_cause} !== {m_rst, m_done, m_cause}) begin
                n_err++;
                $display("FAIL btn_model cyc=%0d got=%b/%b/%0d exp=%b/%b/%0d", u, rst_out, seq_done, rst_cause, m_rst, m_done, m_cause);
            end
            tick(1, 0, 0);
        end
    endtask

    task automatic test_soft();
        logic [N-1:0] exp_r;
        int p_hold;
        int p_rel;
        p_hold = int'($urandom_range(2, 16));
        p_rel  = int'($urandom_range(17, 24));
        tick(1, 1, 0);
        for (int j = 1; j < 32; j++) begin
            exp_r = (j < 17) ? 3'b111 : (j < 21) ? 3'b110 : (j < 25) ? 3'b100 : 3'b000;
            n_cmp++;
            if ({rst_out, seq_done, rst_cause} !== {exp_r, 1'(j >= 25), 2'd2}) begin
                n_err++;
                $display("FAIL soft_req cyc=%0d got=%b/%b/%0d exp=%b/%b/2", j, rst_out, seq_done, rst_cause, exp_r, j >= 25);
            end
            n_cmp++;
            if ({rst_out, seq_done, rst_cause} !== {m_rst, m_done, m_cause}) begin
                n_err++;
                $display("FAIL soft_model cyc=%0d got=%b/%b/%0d exp=%b/%b/%0d", j, rst_out, seq_done, rst_cause, m_rst, m_done, m_cause);
            end
            tick(1, (j == p_hold) || (j == p_rel), 0);
        end
    endtask

    task automatic test_simultaneous();
        for (int j = 0; j < 14; j++) begin
            if (j == 11) begin
                n_cmp++;
                if ({rst_out, seq_done, rst_cause} !== {3'b111, 1'b0, 2'd1}) begin
                    n_err++;
                    $display("FAIL simul_cause got=%b/%b/%0d exp=111/0/1", rst_out, seq_done, rst_cause);
                end
            end
            tick(0, j == 10, 0);
        end
        for (int u = 0; u < 45; u++) begin
            n_cmp++;
            if ({rst_out, seq_done, rst_cause} !== {m_rst, m_done, m_cause}) begin
                n_err++;
                $display("FAIL simul_model cyc=%0d got=%b/%b/%0d exp=%b/%b/%0d", u, rst_out, seq_done, rst_cause, m_rst, m_done, m_cause);
            end
            tick(1, 0, 0);
        end
        n_cmp++;
        if ({rst_out, seq_done, rst_cause} !== {3'b000, 1'b1, 2'd1}) begin
            n_err++;
            $display("FAIL simul_end got=%b/%b/%0d exp=000/1/1", rst_out, seq_done, rst_cause);
        end
    endtask

    task automatic test_reset_mid();
        logic [N-1:0] exp_r;
        tick(1, 1, 0);
        for (int j = 0; j < 18; j++) tick(1, 0, 0);
        n_cmp++;
        if ({rst_out, seq_done, rst_cause} !== {3'b110, 1'b0, 2'd2}) begin
            n_err++;
            $display("FAIL mid_before got=%b/%b/%0d exp=110/0/2", rst_out, seq_done, rst_cause);
        end
        tick(1, 0, 1);
        for (int j = 0; j < 30; j++) begin
            exp_r = (j < 16) ? 3'b111 : (j < 20) ? 3'b110 : (j < 24) ? 3'b100 : 3'b000;
            n_cmp++;
            if ({rst_out, seq_done, rst_cause} !== {exp_r, 1'(j >= 24), 2'd0}) begin
                n_err++;
                $display("FAIL mid_replay cyc=%0d got=%b/%b/%0d exp=%b/%b/0", j, rst_out, seq_done, rst_cause, exp_r, j >= 24);
            end
            tick(1, 0, 0);
        end
    endtask

    task automatic test_random();
        int run_left;
        bit lvl_drv;
        run_left = 0;
        lvl_drv  = 1'b1;
        for (int j = 0; j < 1500; j++) begin
            n_cmp++;
            if ({rst_out, seq_done, rst_cause} !== {m_rst, m_done, m_cause}) begin
                n_err++;
                $display("FAIL random_model cyc=%0d got=%b/%b/%0d exp=%b/%b/%0d", mc, rst_out, seq_done, rst_cause, m_rst, m_done, m_cause);
            end
            if (run_left == 0) begin
                lvl_drv  = ~lvl_drv;
                run_left = lvl_drv ? int'($urandom_range(5, 60)) : int'($urandom_range(1, 20));
            end
            run_left--;
            tick(lvl_drv, $urandom_range(0, 19) == 0, $urandom_range(0, 399) == 0);
        end
    endtask

    initial begin
        ext_rst_n    = 1'b1;
        soft_rst_req = 1'b0;
        reset        = 1'b1;
        for (int i = 0; i < HMAX; i++) hist[i] = 1'b1;
        @(posedge clk);
        #1;
        mc = 0; m_R = 0; m_A = 0; m_lvl = 1'b1; m_evt = 1'b0;
        m_rst = '1; m_done = 1'b0; m_cause = 2'd0;

        test_reset();
        test_short_press();
        test_long_press();
        test_soft();
        test_simultaneous();
        test_reset_mid();
        test_random();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
